// File: rtl/ysyx_041461_lsu_axi_master.sv
// LSU-to-AXI4 bridge: turns one load/store request into a single-beat AXI4
// transaction. Store data/strobes and load data are lane-aligned here.
// Only one transaction is in flight at a time.
module ysyx_041461_lsu_axi_master #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic [1:0]  rresp,
  input  logic [63:0] rdata,
  input  logic        rlast
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  // Offset must be a multiple of the access size; sizes above 8 bytes are illegal.
  function automatic logic misaligned(input logic [2:0] off, input logic [2:0] size);
    case (size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = (off[0] != 1'b0);
      3'd2:    misaligned = (off[1:0] != 2'b00);
      3'd3:    misaligned = (off != 3'b000);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Byte-lane strobe for an access of 1<<size bytes starting at lane off.
  function automatic logic [7:0] strobe(input logic [2:0] off, input logic [2:0] size);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      3'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    strobe = base << off;
  endfunction

  // Right-justify the addressed bytes of a bus beat and zero the rest.
  function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] off,
                                          input logic [2:0] size);
    logic [63:0] shifted;
    shifted = data >> {off, 3'b000};
    case (size)
      3'd0:    extract = {56'd0, shifted[7:0]};
      3'd1:    extract = {48'd0, shifted[15:0]};
      3'd2:    extract = {32'd0, shifted[31:0]};
      3'd3:    extract = shifted;
      default: extract = 64'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        aw_hs_s, w_hs_s;

  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      size_q       <= 3'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 64'd0;
      wstrb_q      <= 8'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic; illegal requests skip the bus and report an error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!req_valid)                             state_d = S_IDLE;
        else if (misaligned(req_addr[2:0], req_size)) state_d = S_RESP;
        else if (req_wen)                           state_d = S_WADDR;
        else                                        state_d = S_RADDR;
      end
      S_WADDR: begin
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) state_d = S_WRESP;
        else                                                  state_d = S_WADDR;
      end
      S_WRESP: begin
        if (bvalid) state_d = S_RESP;
        else        state_d = S_WRESP;
      end
      S_RADDR: begin
        if (arready) state_d = S_RDATA;
        else         state_d = S_RADDR;
      end
      S_RDATA: begin
        if (rvalid) state_d = S_RESP;
        else        state_d = S_RDATA;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the request, track handshakes, capture response/error.
  // resp_valid is registered off the RESP state, so it pulses the cycle after RESP.
  always_comb begin
    addr_d       = addr_q;
    size_d       = size_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = (state_q == S_RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wen_d     = req_wen;
          wdata_d   = req_wdata << {req_addr[2:0], 3'b000};
          wstrb_d   = strobe(req_addr[2:0], req_size);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = 64'd0;
          err_d     = misaligned(req_addr[2:0], req_size);
        end else begin
          err_d = err_q;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q | w_hs_s;
      end
      S_WRESP: begin
        if (bvalid) err_d = (bresp != 2'b00) || (bid != AXI_ID);
        else        err_d = err_q;
      end
      S_RDATA: begin
        if (rvalid) begin
          rdata_d = extract(rdata, addr_q[2:0], size_q);
          err_d   = (rresp != 2'b00) || (rid != AXI_ID) || !rlast;
        end else begin
          rdata_d = rdata_q;
        end
      end
      S_RESP: begin
        resp_rdata_d = wen_q ? 64'd0 : rdata_q;
        resp_err_d   = err_q;
      end
      default: begin
        err_d = err_q;
      end
    endcase
  end

  // Handshake outputs decoded from state and done flags only, never from ready.
  always_comb begin
    req_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_WADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      S_WRESP: bready  = 1'b1;
      S_RADDR: arvalid = 1'b1;
      S_RDATA: rready  = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign awid       = AXI_ID;
  assign awaddr     = addr_q;
  assign awlen      = 8'd0;
  assign awsize     = size_q;
  assign awburst    = 2'b01;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = wvalid;
  assign arid       = AXI_ID;
  assign araddr     = addr_q;
  assign arlen      = 8'd0;
  assign arsize     = size_q;
  assign arburst    = 2'b01;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_041461_lsu_axi_master.sv
// Randomized bench for the LSU AXI master: a cycle-driven slave model with
// programmable wait states, and an arithmetic reference for alignment,
// error and latency.
module tb_ysyx_041461_lsu_axi_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic        arvalid, arready, rvalid, rready, rlast;

  int n_pass;
  int n_total;

  ysyx_041461_lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp),
    .rdata(rdata), .rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rresp = 2'b00; rdata = 64'd0; rlast = 1'b0;
  endtask

  // d0: aw/ar wait, d1: w wait, d2: b/r wait after the address phase completes.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] wd, input int d0, input int d1, input int d2,
                         input logic [63:0] rd, input logic [1:0] rsp, input logic [3:0] id,
                         input logic last);
    int off, bytes, cyc, exp_lat, resp_cyc, viol;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic misal, exp_err, got_err, seen, prev_rdy, rdy_in_resp, any_bus;
    logic aw_done, w_done, b_done, ar_done, r_done;
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic [63:0] exp_wd, exp_rd, mask, got_rd;
    logic [7:0] exp_strb;

    off      = int'(addr[2:0]);
    bytes    = 1 << size;
    misal    = (size > 3'd3) || ((off % bytes) != 0);
    exp_wd   = wd << (8 * off);
    exp_strb = 8'(((64'd1 << bytes) - 64'd1) << off);
    mask     = (bytes >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
    exp_rd   = (wen || misal) ? 64'd0 : ((rd >> (8 * off)) & mask);
    if (misal)    exp_err = 1'b1;
    else if (wen) exp_err = (rsp != 2'b00) || (id != 4'd1);
    else          exp_err = (rsp != 2'b00) || (id != 4'd1) || !last;
    if (misal)    exp_lat = 1;
    else if (wen) exp_lat = ((d0 > d1) ? d0 : d1) + d2 + 3;
    else          exp_lat = d0 + d2 + 3;

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd;
    step();
    req_valid = 1'b0; req_wdata = {$urandom, $urandom};

    viol = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    seen = 0; cyc = 0; prev_rdy = 1'b1; rdy_in_resp = 1'b1; any_bus = 0;
    resp_cyc = -1; got_rd = 64'd0; got_err = 1'b0;
    while (!seen && cyc < 200) begin
      if (resp_valid) begin
        seen = 1; resp_cyc = cyc; got_rd = resp_rdata; got_err = resp_err;
        rdy_in_resp = prev_rdy;
      end else begin
        any_bus = any_bus | awvalid | wvalid | arvalid;
        if (aw_done && awvalid) viol++;
        if (w_done && wvalid) viol++;
        if (ar_done && arvalid) viol++;
        if (!aw_done && aw_cnt > 0 && !awvalid) viol++;
        if (!w_done && w_cnt > 0 && !wvalid) viol++;
        if (!ar_done && ar_cnt > 0 && !arvalid) viol++;
        if (!wen && (awvalid || wvalid)) viol++;
        if (wen && arvalid) viol++;
        clear_slave();
        if (!aw_done && awvalid) begin
          if (aw_cnt == 0) begin
            check("awaddr", 64'(awaddr), 64'(addr));
            check("awsize", 64'(awsize), 64'(size));
            check("awlen_burst_id", {52'd0, awlen, awburst, awid}, {52'd0, 8'd0, 2'b01, 4'd1});
          end
          awready = (aw_cnt >= d0);
          aw_cnt++;
        end
        if (!w_done && wvalid) begin
          if (w_cnt == 0) begin
            check("wdata", wdata, exp_wd);
            check("wstrb_wlast", {55'd0, wstrb, wlast}, {55'd0, exp_strb, 1'b1});
          end
          wready = (w_cnt >= d1);
          w_cnt++;
        end
        if (aw_done && w_done && !b_done) begin
          bvalid = (b_cnt >= d2); bid = id; bresp = rsp;
          b_cnt++;
        end
        if (!ar_done && arvalid) begin
          if (ar_cnt == 0) begin
            check("araddr", 64'(araddr), 64'(addr));
            check("arsize", 64'(arsize), 64'(size));
            check("arlen_burst_id", {52'd0, arlen, arburst, arid}, {52'd0, 8'd0, 2'b01, 4'd1});
          end
          arready = (ar_cnt >= d0);
          ar_cnt++;
        end
        if (ar_done && !r_done) begin
          rvalid = (r_cnt >= d2); rdata = rd; rresp = rsp; rid = id; rlast = last;
          r_cnt++;
        end
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        b_fire  = bvalid && bready;
        ar_fire = arvalid && arready;
        r_fire  = rvalid && rready;
        prev_rdy = req_ready;
        step();
        cyc++;
        if (aw_fire) aw_done = 1;
        if (w_fire)  w_done = 1;
        if (b_fire)  b_done = 1;
        if (ar_fire) ar_done = 1;
        if (r_fire)  r_done = 1;
      end
    end
    clear_slave();
    check("resp_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("latency", 64'(resp_cyc), 64'(exp_lat));
      check("resp_rdata", got_rd, exp_rd);
      check("resp_err", 64'(got_err), 64'(exp_err));
      check("req_ready_in_resp", 64'(rdy_in_resp), 64'd0);
    end
    check("bus_activity", 64'(any_bus), 64'(!misal));
    check("protocol_viol", 64'(viol), 64'd0);
    step();
    check("resp_pulse_width", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic        r_wen, r_last;
    logic [2:0]  r_size;
    logic [31:0] r_addr, r_mask;
    logic [1:0]  r_rsp;
    logic [3:0]  r_id;

    n_pass = 0; n_total = 0;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
    req_size = 3'd0; req_wdata = 64'd0;
    clear_slave();
    step(); step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    check("rst_resp", {62'd0, resp_valid, resp_err}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_latched", {24'd0, awaddr, wstrb}, 64'd0);
    check("rst_wdata", wdata, 64'd0);
    rst = 1'b0;
    step();

    // Directed cases.
    run_txn(1'b0, 32'h0200_bff8, 3'd3, 64'd0, 0, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 4'd1, 1'b1);
    run_txn(1'b1, 32'h8000_0006, 3'd1, 64'h0000_0000_0000_ABCD, 3, 0, 0, 64'd0, 2'b00, 4'd1, 1'b1);
    run_txn(1'b0, 32'h8000_0003, 3'd0, 64'd0, 0, 0, 0, 64'h0000_0000_DE00_0000, 2'b00, 4'd1, 1'b1);
    run_txn(1'b1, 32'h8000_0002, 3'd2, 64'h1234_5678, 0, 0, 0, 64'd0, 2'b00, 4'd1, 1'b1);
    run_txn(1'b1, 32'h8000_0010, 3'd2, 64'hCAFE_F00D, 0, 2, 1, 64'd0, 2'b10, 4'd1, 1'b1);
    run_txn(1'b0, 32'h8000_0020, 3'd2, 64'd0, 1, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd7, 1'b1);
    run_txn(1'b0, 32'h8000_0028, 3'd3, 64'd0, 0, 0, 0, 64'h5555_AAAA_5555_AAAA, 2'b00, 4'd1, 1'b0);

    // Reset while the write address phase is stalled.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0040; req_size = 3'd3;
    req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    req_valid = 1'b0;
    step();
    check("mid_rst_awvalid_before", 64'(awvalid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valids", {62'd0, awvalid, wvalid}, 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    run_txn(1'b1, 32'h8000_0044, 3'd2, 64'h7777_8888, 0, 0, 0, 64'd0, 2'b00, 4'd1, 1'b1);

    // Randomized mix of loads/stores, sizes, offsets, wait states and responses.
    for (int i = 0; i < 40; i++) begin
      r_wen  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        r_mask = 32'hFFFF_FFFF << r_size;
        r_addr = r_addr & r_mask;
      end
      r_rsp  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_id   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'd1;
      r_last = ($urandom_range(0, 7) != 0);
      run_txn(r_wen, r_addr, r_size, {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              {$urandom, $urandom}, r_rsp, r_id, r_last);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
